// File: rtl/usb_ep6_writer.sv
// CY68013 EP6 slave-FIFO write controller: one stream word per SLWR strobe, PKTEND on
// frames that end mid-packet. All USB pin outputs come straight from flops.
module usb_ep6_writer #(
  parameter int unsigned WR_SETUP   = 2,
  parameter int unsigned WR_LOW     = 4,
  parameter int unsigned WR_HOLD    = 2,
  parameter int unsigned PKT_WORDS  = 256,
  parameter int unsigned PKTEND_LOW = 4
) (
  input  logic        fpga_gclk,
  input  logic        reset_n,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        usb_flagc,
  output logic [1:0]  usb_fifoaddr,
  output logic        usb_slcs,
  output logic        usb_sloe,
  output logic        usb_slrd,
  output logic        usb_slwr,
  output logic        usb_pktend,
  output logic [15:0] usb_fd_out,
  output logic        usb_fd_oe,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned PktW   = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int unsigned MaxA   = (WR_SETUP > WR_LOW) ? WR_SETUP : WR_LOW;
  localparam int unsigned MaxB   = (WR_HOLD > PKTEND_LOW) ? WR_HOLD : PKTEND_LOW;
  localparam int unsigned MaxLen = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;

  // Counter is loaded with length-1 and the state exits when it reaches zero.
  localparam logic [CntW-1:0] SetupLd  = CntW'(WR_SETUP - 1);
  localparam logic [CntW-1:0] LowLd    = CntW'(WR_LOW - 1);
  localparam logic [CntW-1:0] HoldLd   = CntW'(WR_HOLD - 1);
  localparam logic [CntW-1:0] PktendLd = CntW'(PKTEND_LOW - 1);
  localparam logic [PktW-1:0] PktLast  = PktW'(PKT_WORDS - 1);
  localparam logic [1:0]      Ep6Addr  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StWrLow,
    StHold,
    StPktend
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PktW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0]     data_q, data_d;
  logic            last_q, last_d;
  logic            frame_done_q, frame_done_d;
  logic            flagc_meta_q, flagc_s_q;
  logic            slwr_q, slwr_d;
  logic            pktend_q, pktend_d;
  logic            fd_oe_q, fd_oe_d;
  logic [1:0]      fifoaddr_q, fifoaddr_d;
  logic            busy_q, busy_d;
  logic            xfer;

  // usb_flagc comes from the CY68013 clock domain.
  always_ff @(posedge fpga_gclk or negedge reset_n) begin
    if (!reset_n) begin
      flagc_meta_q <= 1'b0;
      flagc_s_q    <= 1'b0;
    end else begin
      flagc_meta_q <= usb_flagc;
      flagc_s_q    <= flagc_meta_q;
    end
  end

  assign s_ready = (state_q == StIdle) && flagc_s_q;
  assign xfer    = s_valid && s_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pkt_cnt_d    = pkt_cnt_q;
    data_d       = data_q;
    last_d       = last_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          data_d  = s_data;
          last_d  = s_last;
          cnt_d   = SetupLd;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          cnt_d   = LowLd;
          state_d = StWrLow;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWrLow: begin
        if (cnt_q == '0) begin
          cnt_d   = HoldLd;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          if (pkt_cnt_q == PktLast) begin
            // Full packet: the CY68013 commits it without PKTEND.
            pkt_cnt_d    = '0;
            frame_done_d = last_q;
            state_d      = StIdle;
          end else if (last_q) begin
            pkt_cnt_d = pkt_cnt_q + PktW'(1);
            cnt_d     = PktendLd;
            state_d   = StPktend;
          end else begin
            pkt_cnt_d = pkt_cnt_q + PktW'(1);
            state_d   = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StPktend: begin
        if (cnt_q == '0) begin
          pkt_cnt_d    = '0;
          frame_done_d = 1'b1;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Pin levels are decoded from the next state so the flops line up with state_q.
  always_comb begin
    slwr_d     = (state_d != StWrLow);
    pktend_d   = (state_d != StPktend);
    fd_oe_d    = (state_d == StSetup) || (state_d == StWrLow) || (state_d == StHold);
    fifoaddr_d = (state_d == StIdle) ? 2'b00 : Ep6Addr;
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge fpga_gclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pkt_cnt_q    <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      slwr_q       <= 1'b1;
      pktend_q     <= 1'b1;
      fd_oe_q      <= 1'b0;
      fifoaddr_q   <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      data_q       <= data_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
      slwr_q       <= slwr_d;
      pktend_q     <= pktend_d;
      fd_oe_q      <= fd_oe_d;
      fifoaddr_q   <= fifoaddr_d;
      busy_q       <= busy_d;
    end
  end

  // This block only ever writes: chip always selected, read path parked.
  assign usb_slcs     = 1'b0;
  assign usb_sloe     = 1'b1;
  assign usb_slrd     = 1'b1;
  assign usb_slwr     = slwr_q;
  assign usb_pktend   = pktend_q;
  assign usb_fd_out   = data_q;
  assign usb_fd_oe    = fd_oe_q;
  assign usb_fifoaddr = fifoaddr_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_usb_ep6_writer.sv
// Directed and randomized bench for usb_ep6_writer; a pin monitor reconstructs written words
// and strobe timing, which are compared against a frame-level reference model.
module tb_usb_ep6_writer;

  localparam int unsigned WrSetup   = 2;
  localparam int unsigned WrLow     = 4;
  localparam int unsigned WrHold    = 2;
  localparam int unsigned PktWords  = 256;
  localparam int unsigned PktendLow = 4;

  logic        fpga_gclk = 1'b0;
  logic        reset_n   = 1'b0;
  logic [15:0] s_data    = '0;
  logic        s_valid   = 1'b0;
  logic        s_last    = 1'b0;
  logic        usb_flagc = 1'b1;
  logic        s_ready;
  logic [1:0]  usb_fifoaddr;
  logic        usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_pktend;
  logic [15:0] usb_fd_out;
  logic        usb_fd_oe, busy, frame_done;

  usb_ep6_writer #(
    .WR_SETUP  (WrSetup),
    .WR_LOW    (WrLow),
    .WR_HOLD   (WrHold),
    .PKT_WORDS (PktWords),
    .PKTEND_LOW(PktendLow)
  ) dut (
    .fpga_gclk   (fpga_gclk),
    .reset_n     (reset_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .usb_flagc   (usb_flagc),
    .usb_fifoaddr(usb_fifoaddr),
    .usb_slcs    (usb_slcs),
    .usb_sloe    (usb_sloe),
    .usb_slrd    (usb_slrd),
    .usb_slwr    (usb_slwr),
    .usb_pktend  (usb_pktend),
    .usb_fd_out  (usb_fd_out),
    .usb_fd_oe   (usb_fd_oe),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #10 fpga_gclk = ~fpga_gclk;

  int cyc = 0;
  always @(posedge fpga_gclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Pin monitor results (written only by the monitor process).
  logic [15:0] obs_q[$];
  int n_fall = 0, n_rise = 0, n_pkt = 0, n_done = 0, n_viol = 0, n_bad = 0;
  int rise_cyc = 0, fall_cyc = 0, pkt_cyc = 0, done_cyc = 0;

  // Reference model state (written only by the stimulus process).
  logic [15:0] exp_q[$];
  int frame_len = 0, exp_pkt = 0, exp_done = 0;

  initial begin : monitor
    logic        p_slwr, p_pkt, p_oe, p_done, after_rise;
    logic [15:0] p_fd;
    int          low_len, pk_len, setup_run, hold_run;
    p_slwr = 1'b1; p_pkt = 1'b1; p_oe = 1'b0; p_done = 1'b0; after_rise = 1'b0;
    p_fd = '0; low_len = 0; pk_len = 0; setup_run = 0; hold_run = 0;
    forever begin
      @(negedge fpga_gclk);
      if (!reset_n) begin
        p_slwr = 1'b1; p_pkt = 1'b1; p_oe = 1'b0; p_done = 1'b0; after_rise = 1'b0;
        low_len = 0; pk_len = 0; setup_run = 0; hold_run = 0;
      end else begin
        if (usb_slcs !== 1'b0 || usb_sloe !== 1'b1 || usb_slrd !== 1'b1) n_viol++;
        if (usb_slwr === 1'b0) begin
          low_len++;
          if (usb_fd_oe !== 1'b1 || usb_fifoaddr !== 2'b10) n_viol++;
          if (p_slwr === 1'b1) begin
            n_fall++;
            fall_cyc = cyc;
            if (setup_run != WrSetup) n_bad++;
          end
        end else if (p_slwr === 1'b0) begin
          n_rise++;
          rise_cyc = cyc;
          obs_q.push_back(usb_fd_out);
          if (low_len != WrLow) n_bad++;
          low_len = 0; after_rise = 1'b1; hold_run = 0;
        end
        if (usb_slwr === 1'b1 && usb_fd_oe === 1'b1) begin
          if (after_rise) hold_run++;
          else setup_run++;
        end
        if (usb_fd_oe === 1'b1 && p_oe === 1'b1 && usb_fd_out !== p_fd) n_viol++;
        if (usb_fd_oe === 1'b0 && p_oe === 1'b1) begin
          if (!after_rise || hold_run != WrHold) n_bad++;
          after_rise = 1'b0; setup_run = 0;
        end
        if (usb_pktend === 1'b0) begin
          pk_len++;
          if (usb_fd_oe !== 1'b0 || usb_fifoaddr !== 2'b10) n_viol++;
          if (p_pkt === 1'b1) begin
            n_pkt++;
            pkt_cyc = cyc;
          end
        end else if (p_pkt === 1'b0) begin
          if (pk_len != PktendLow) n_bad++;
          pk_len = 0;
        end
        if (frame_done === 1'b1) begin
          n_done++;
          done_cyc = cyc;
          if (p_done === 1'b1) n_viol++;
        end
        p_slwr = usb_slwr; p_pkt = usb_pktend; p_oe = usb_fd_oe;
        p_done = frame_done; p_fd = usb_fd_out;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step to just after the falling edge, after the monitor has sampled.
  task automatic step();
    @(negedge fpga_gclk);
    #1;
  endtask

  task automatic model_push(input logic [15:0] d, input logic l);
    exp_q.push_back(d);
    frame_len++;
    if (l) begin
      exp_done++;
      if (frame_len % PktWords != 0) exp_pkt++;
      frame_len = 0;
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l, input int gap, output int xcyc);
    int w;
    repeat (gap) step();
    s_data = d; s_last = l; s_valid = 1'b1;
    w = 0;
    while (s_ready !== 1'b1 && w < 2000) begin
      step();
      w++;
    end
    if (s_ready !== 1'b1) check("accept_timeout", 32'(s_ready), 1);
    else model_push(d, l);
    xcyc = cyc;
    step();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int w;
    w = 0;
    while (frame_done !== 1'b1 && w < 5000) begin
      step();
      w++;
    end
    if (frame_done !== 1'b1) check(tag, 32'(frame_done), 1);
    repeat (3) step();
  endtask

  initial begin : stim
    int b_fall, b_rise, b_pkt, b_done, xc, c0, w, left, len, gap;
    logic [15:0] word;

    // Reset state
    repeat (3) step();
    check("rst_slwr", 32'(usb_slwr), 1);
    check("rst_pktend", 32'(usb_pktend), 1);
    check("rst_fd_oe", 32'(usb_fd_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_fifoaddr", 32'(usb_fifoaddr), 0);
    check("rst_fd_out", 32'(usb_fd_out), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_static", {29'd0, usb_slcs, usb_sloe, usb_slrd}, 3);
    reset_n = 1'b1;
    repeat (4) step();
    check("ready_after_rst", 32'(s_ready), 1);

    // Single word, short packet
    b_rise = n_rise; b_pkt = n_pkt; b_done = n_done;
    send(16'hA5A5, 1'b1, 0, xc);
    wait_done("single_done_timeout");
    check("single_rises", 32'(n_rise - b_rise), 1);
    check("single_pktend", 32'(n_pkt - b_pkt), 1);
    check("single_done", 32'(n_done - b_done), 1);
    check("single_latency", 32'(done_cyc - xc), 13);
    check("single_pkt_after_rise", 32'(pkt_cyc - rise_cyc), 2);

    // Exactly one full packet
    b_rise = n_rise; b_pkt = n_pkt; b_done = n_done;
    for (int i = 0; i < 256; i++) send(16'(i), i == 255, 0, xc);
    wait_done("full_done_timeout");
    check("full_rises", 32'(n_rise - b_rise), 256);
    check("full_pktend", 32'(n_pkt - b_pkt), 0);
    check("full_done", 32'(n_done - b_done), 1);
    check("full_done_after_hold", 32'(done_cyc - rise_cyc), 2);

    // Full packet plus partial
    b_rise = n_rise; b_pkt = n_pkt; b_done = n_done;
    for (int i = 0; i < 300; i++) send(16'(16'h1000 + i), i == 299, 0, xc);
    wait_done("p300_done_timeout");
    check("p300_rises", 32'(n_rise - b_rise), 300);
    check("p300_pktend", 32'(n_pkt - b_pkt), 1);
    check("p300_done", 32'(n_done - b_done), 1);
    check("p300_pkt_after_last", 32'(pkt_cyc - rise_cyc), 2);

    // Flag handling
    b_fall = n_fall; b_rise = n_rise;
    usb_flagc = 1'b0;
    repeat (4) step();
    s_data = 16'hBEEF; s_last = 1'b0; s_valid = 1'b1;
    repeat (20) step();
    check("flag_low_ready", 32'(s_ready), 0);
    check("flag_low_no_slwr", 32'(n_fall - b_fall), 0);
    usb_flagc = 1'b1;
    c0 = cyc;
    w = 0;
    while (usb_slwr !== 1'b0 && w < 30) begin
      step();
      w++;
    end
    check("flag_rise_latency_ok", 32'((fall_cyc - c0 >= 5) && (fall_cyc - c0 <= 6)), 1);
    model_push(16'hBEEF, 1'b0);
    usb_flagc = 1'b0;
    s_data = 16'hCAFE; s_last = 1'b1;
    repeat (30) step();
    check("flag_drop_completes", 32'(n_rise - b_rise), 1);
    check("flag_drop_no_accept", 32'(n_fall - b_fall), 1);
    check("flag_drop_ready", 32'(s_ready), 0);
    check("flag_drop_idle", 32'(busy), 0);
    usb_flagc = 1'b1;
    w = 0;
    while (s_ready !== 1'b1 && w < 30) begin
      step();
      w++;
    end
    check("flag_restore_ready", 32'(s_ready), 1);
    model_push(16'hCAFE, 1'b1);
    step();
    s_valid = 1'b0; s_last = 1'b0;
    wait_done("flag_done_timeout");

    // Reset in the middle of word 10's write strobe
    for (int i = 0; i < 10; i++) send(16'(16'h2000 + i), 1'b0, 0, xc);
    s_data = 16'h200A; s_last = 1'b0; s_valid = 1'b1;
    w = 0;
    while (s_ready !== 1'b1 && w < 30) begin
      step();
      w++;
    end
    step();
    s_valid = 1'b0;
    w = 0;
    while (usb_slwr !== 1'b0 && w < 30) begin
      step();
      w++;
    end
    step();
    reset_n = 1'b0;
    #1;
    check("midrst_slwr", 32'(usb_slwr), 1);
    check("midrst_fd_oe", 32'(usb_fd_oe), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_pktend", 32'(usb_pktend), 1);
    frame_len = 0;
    repeat (3) step();
    reset_n = 1'b1;
    b_rise = n_rise; b_pkt = n_pkt; b_done = n_done;
    for (int i = 0; i < 256; i++) send(16'(16'h3000 + i), i == 255, 0, xc);
    wait_done("postrst_done_timeout");
    check("postrst_rises", 32'(n_rise - b_rise), 256);
    check("postrst_pktend", 32'(n_pkt - b_pkt), 0);
    check("postrst_done", 32'(n_done - b_done), 1);

    // Randomized frames with gaps and flag drops
    left = 1000;
    while (left > 0) begin
      case ($urandom_range(0, 4))
        0: len = 1;
        1: len = 255;
        2: len = 256;
        3: len = 257;
        default: len = int'($urandom_range(2, 40));
      endcase
      if (len > left) len = left;
      for (int i = 0; i < len; i++) begin
        gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
        if ($urandom_range(0, 15) == 0) begin
          usb_flagc = 1'b0;
          repeat ($urandom_range(1, 6)) step();
          usb_flagc = 1'b1;
        end
        word = 16'($urandom());
        send(word, i == len - 1, gap, xc);
      end
      left -= len;
    end
    w = 0;
    while (busy !== 1'b0 && w < 100) begin
      step();
      w++;
    end
    repeat (20) step();

    // Whole-run scoreboard
    check("word_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("word_%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
    check("pktend_total", 32'(n_pkt), 32'(exp_pkt));
    check("frame_done_total", 32'(n_done), 32'(exp_done));
    check("strobe_shape_errs", 32'(n_bad), 0);
    check("pin_protocol_errs", 32'(n_viol), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
